if_id_stage: RTL
================

Name: if_id_stage

Overview:
- IF/ID pipeline register, sitting between the PC register / instruction memory and the decode stage.
- Captures the fetched instruction and its PC every cycle.
- Early-decodes jump and branch-equal from the held instruction and drives the PC's j_label, b_label, j_address and b_address inputs.
- Squashes the wrong-path instruction fetched in the same cycle as a taken redirect, inserting one bubble.

Parameters:
- OPC_J, 6'b000010, opcode of unconditional jump.
- OPC_BEQ, 6'b000100, opcode of branch-if-equal.
- NOP_WORD, 32'h00000000, instruction word presented to decode when the stage is invalid.
- CNT_W, 32, width of performance counters.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- pc_in  input  32  current PC value (PC_out of the PC register).
- instr_in  input  32  instruction-memory word at pc_in (combinational read).
- zero  input  1  branch compare result for the instruction in ID; same signal the PC consumes.
- id_instr  output  32  instruction held for decode; NOP_WORD when id_valid=0.
- id_pc  output  32  PC of id_instr.
- id_valid  output  1  ID holds a real (non-squashed) instruction.
- j_label  output  1  to PC: jump in ID.
- b_label  output  1  to PC: BEQ in ID (PC gates with zero).
- j_address  output  26  to PC: id_instr[25:0].
- b_address  output  16  to PC: id_instr[15:0].
- instr_count  output  CNT_W  valid instructions that entered ID (FETCH_PERF_EN only).
- squash_count  output  CNT_W  squashed fetches (FETCH_PERF_EN only).

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state:
  - id_valid=0, id_instr=NOP_WORD, id_pc=0.
  - state=FETCH, both counters=0.
  - j_label=b_label=0 while rst is high.
- Registers: instr_q, pc_q, valid_q, state.
- id_instr = valid_q ? instr_q : NOP_WORD.
- id_pc = pc_q.
- j_address and b_address are always sliced from id_instr.
- Decode (combinational from held register):
  - j_label = valid_q && id_instr[31:26]==OPC_J.
  - b_label = valid_q && id_instr[31:26]==OPC_BEQ.
- redirect = j_label || (b_label && zero). The PC loads the target on this same edge.
- State machine, 2 states:
  - FETCH: if redirect, go to SQUASH; else stay.
  - SQUASH: always return to FETCH next edge.
- Per-edge update (non-reset):
  - instr_q<=instr_in and pc_q<=pc_in every edge.
  - valid_q <= !redirect. The word fetched during a redirect cycle is wrong-path.
  - No stall input: the stage advances every cycle.
- Latency: a fetched word appears in ID exactly 1 cycle after pc_in presents its address.
- Redirect penalty: exactly one bubble (id_valid=0 for one cycle); the target instruction is valid in ID 2 edges after the redirect cycle.
- Boundary conditions:
  - In SQUASH, valid_q=0, so j_label=b_label=0. A squashed jump/branch can never redirect, and back-to-back redirects are impossible.
  - BEQ with zero=0: no redirect, no bubble, fall-through continues.
  - Jump and BEQ opcodes are mutually exclusive; no priority rule is needed. The PC gives j_label priority anyway.
  - The first valid ID instruction after reset is the word at PC 0, one edge after rst falls.
  - Counters wrap modulo 2^CNT_W.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - instr_count increments on every non-reset edge where the incoming word is marked valid (!redirect).
  - squash_count increments on every non-reset edge where redirect=1.
- Undefined: no counter registers are built; instr_count and squash_count are tied to 0.

Test Plan:
- Reset then release: sequential words at PC 0,1,2 → id_valid=0 during reset; id_pc=0,1,2 on consecutive cycles, id_instr matching, id_valid=1.
- Jump at PC 3 (opcode 000010, target 26'd20) → j_label=1, j_address=20 for one cycle; next cycle id_valid=0 (id_instr=0); following cycle id_pc=20, id_valid=1.
- BEQ at PC 5 with zero=1, offset 16'd40 → b_label=1, b_address=40; one bubble; then id_pc=40.
- BEQ at PC 5 with zero=0 → b_label=1, no bubble; id_pc=6 valid next cycle.
- Jump immediately followed by a jump at PC+1 → the second jump is squashed: j_label stays 0 in the bubble cycle, and only the first target is taken.
- With FETCH_PERF_EN: 10 straight-line instructions plus 2 taken redirects → squash_count=2, instr_count=10 + (redirect targets entered). Assert rst mid-run → both counters 0, id_valid=0 next cycle.

Source files
------------

// File: rtl/if_id_stage.sv
// if_id_stage: IF/ID pipeline register between fetch and decode.
// Holds the fetched word and its PC, early-decodes J/BEQ for the PC register,
// and squashes the wrong-path word fetched in a taken-redirect cycle.
// Optional build macro FETCH_PERF_EN adds instruction/squash counters;
// without it both counter outputs are tied to zero.
module if_id_stage #(
  parameter logic [5:0]  OPC_J    = 6'b000010,
  parameter logic [5:0]  OPC_BEQ  = 6'b000100,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_in,
  input  logic [31:0]      instr_in,
  input  logic             zero,
  output logic [31:0]      id_instr,
  output logic [31:0]      id_pc,
  output logic             id_valid,
  output logic             j_label,
  output logic             b_label,
  output logic [25:0]      j_address,
  output logic [15:0]      b_address,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] squash_count
);

  typedef enum logic {
    FETCH  = 1'b0,
    SQUASH = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        valid_q, valid_d;
  logic [5:0]  opcode;
  logic        redirect;

  // Present the held word to decode and early-decode control transfers
  always_comb begin
    id_instr  = valid_q ? instr_q : NOP_WORD;
    id_pc     = pc_q;
    id_valid  = valid_q;
    j_address = id_instr[25:0];
    b_address = id_instr[15:0];
    opcode    = id_instr[31:26];
    j_label   = !rst && valid_q && (opcode == OPC_J);
    b_label   = !rst && valid_q && (opcode == OPC_BEQ);
    redirect  = j_label || (b_label && zero);
  end

  // Next-state: capture every cycle, mark the redirect-cycle fetch as wrong-path
  always_comb begin
    state_d = state_q;
    instr_d = instr_in;
    pc_d    = pc_in;
    valid_d = !redirect;
    case (state_q)
      FETCH:   if (redirect) state_d = SQUASH;
      SQUASH:  state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Pipeline and state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      instr_q <= NOP_WORD;
      pc_q    <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic [CNT_W-1:0] squash_cnt_q, squash_cnt_d;

  // Count words entering ID as valid versus words squashed by a redirect
  always_comb begin
    instr_cnt_d  = instr_cnt_q;
    squash_cnt_d = squash_cnt_q;
    if (redirect) squash_cnt_d = squash_cnt_q + CNT_W'(1);
    else          instr_cnt_d  = instr_cnt_q + CNT_W'(1);
  end

  // Counter registers, wrapping naturally at full width
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q  <= '0;
      squash_cnt_q <= '0;
    end else begin
      instr_cnt_q  <= instr_cnt_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

  assign instr_count  = instr_cnt_q;
  assign squash_count = squash_cnt_q;
`else
  assign instr_count  = '0;
  assign squash_count = '0;
`endif

endmodule
